dispatch: RTL and testbench
===========================

DISPATCH -- requirements
Module: dispatch

Interface
REQ-001 The module SHALL have these ports, one per line as: name  direction  width  meaning.
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- valid_in  in  1  renamed instruction present on r_data/Opcode.
- r_data  in  rename_data  renamed instruction: ps1, ps2, pd_new, pd_old, imm, rob_tag.
- Opcode  in  7  RISC-V opcode of r_data.
- ready_out  out  1  dispatch can accept an instruction this cycle.
- rob_full  in  1  ROB has no free entry.
- rob_index  in  5  ROB tail index that the next allocation will receive.
- rob_alloc  out  1  one-cycle pulse that allocates the ROB tail entry.
- alu_full  in  1  ALU reservation station full.
- br_full  in  1  branch reservation station full.
- lsu_full  in  1  load/store reservation station full.
- di_en_alu  out  1  write strobe to the ALU reservation station.
- di_en_br  out  1  write strobe to the branch reservation station.
- di_en_lsu  out  1  write strobe to the load/store reservation station.
- data_out  out  rename_data  head instruction driven to all reservation stations.
- opcode_out  out  7  head opcode.
- fu_out  out  2  head class: 0 ALU, 1 branch, 2 LSU.
- rob_index_out  out  5  equals rob_index; written into the reservation station entry.
- mispredict  in  1  flush request.

Function
REQ-002 Dispatch SHALL hold a 2-entry in-order FIFO of {r_data, Opcode, class}.
REQ-003 The class SHALL be decoded at enqueue as follows.
- ALU (0): 0110011, 0010011, 0110111, 0010111, and any unlisted opcode.
- Branch (1): 1100011, 1101111, 1100111.
- LSU (2): 0000011, 0100011.
REQ-004 ready_out SHALL be 1 when count < 2 and mispredict = 0, and 0 otherwise; it is combinational from count and mispredict.
REQ-005 Enqueue SHALL occur at the clock edge when valid_in = 1 and ready_out = 1; in all other cases r_data is ignored.
REQ-006 The head SHALL dispatch when all of the following hold: count > 0, rob_full = 0, the full flag of the head class's station = 0, and mispredict = 0.
REQ-007 In a dispatch cycle the outputs SHALL behave as follows.
- Exactly one di_en_* is 1, selected by the head class.
- rob_alloc = 1.
- data_out, opcode_out and fu_out show the head.
- rob_index_out = rob_index.
- All of these are combinational; the head is dequeued at the next edge.
REQ-008 When the head is not dispatching, di_en_* and rob_alloc SHALL be 0; data_out, opcode_out and fu_out still reflect the head, or are all-zero when count = 0.
REQ-009 Dispatch SHALL be strictly in order: a blocked head blocks the younger entry, even when the younger entry's station has space.
REQ-010 When enqueue and dequeue occur in the same cycle, count SHALL be unchanged, and the new entry SHALL take the tail slot with correct wrap of the 1-bit read and write pointers.
REQ-011 Throughput SHALL be 1 instruction per cycle; latency from enqueue to earliest di_en SHALL be 1 cycle (the entry is visible the cycle after the enqueue edge).
REQ-012 While mispredict = 1, the module SHALL suppress all di_en_* and rob_alloc and block enqueue; at that edge count and both pointers SHALL be cleared.
REQ-013 When mispredict arrives together with valid_in, the incoming instruction SHALL be dropped.
REQ-014 count SHALL never exceed 2 and never underflow.

Reset
REQ-015 When reset = 1 at a clock edge, count, rd_ptr, wr_ptr and all FIFO storage SHALL be cleared to 0.
REQ-016 During reset and in the first cycle after it, outputs SHALL be as follows.
- ready_out = 1 while reset is low.
- di_en_*, rob_alloc, fu_out and opcode_out = 0.
- data_out = all-zero.
REQ-017 Reset SHALL take priority over mispredict and enqueue; reset asserted mid-stream SHALL discard all buffered instructions.

Verification
REQ-018 The bench SHALL cover the following directed scenarios.
- Basic: enqueue an R-type (Opcode 0110011, pd_new = 20), rob_index = 3, all stations free -> next cycle di_en_alu = 1, fu_out = 0, rob_alloc = 1, rob_index_out = 3, data_out.pd_new = 20; one cycle later count = 0.
- Routing: enqueue 1100011 then 0000011 back-to-back -> di_en_br on cycle 1 and di_en_lsu on cycle 2, each exactly one cycle long.
- Backpressure/in-order: br_full = 1, enqueue a branch then an ALU op, then a third valid_in -> ready_out = 0 with count = 2, no di_en_* fires; after br_full drops, the branch dispatches first and the ALU op the next cycle.
- ROB full: rob_full = 1 with one ALU op buffered for 5 cycles -> rob_alloc and di_en_alu stay 0; the op dispatches in the cycle rob_full drops.
- Flush: two entries buffered, mispredict = 1 for one cycle together with valid_in = 1 -> no di_en_* in that cycle; next cycle count = 0, ready_out = 1, and the incoming op is absent.
- Reset mid-operation: two entries buffered, reset = 1 -> after the edge count = 0 and all strobes are 0; the first enqueue after reset dispatches normally.

Source files
------------

// File: rtl/dispatch.sv
// rtl/dispatch.sv - in-order two-entry dispatch buffer feeding ALU, branch and LSU reservation stations
//
// Purpose: buffers renamed instructions in a 2-deep in-order FIFO, classifies
// each by opcode at enqueue, and hands the head to its reservation station
// while allocating the ROB tail entry in the same cycle.
//
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   valid_in, r_data,
//   Opcode, ready_out     - rename-side handshake (enqueue on valid_in & ready_out)
//   rob_full, rob_index,
//   rob_alloc             - ROB availability, tail index, allocate pulse
//   alu_full, br_full,
//   lsu_full              - reservation station full flags
//   di_en_alu, di_en_br,
//   di_en_lsu             - reservation station write strobes
//   data_out, opcode_out,
//   fu_out, rob_index_out - head instruction presented to all stations
//   mispredict            - flush request

package dispatch_pkg;
  typedef struct packed {
    logic [5:0]  ps1;
    logic [5:0]  ps2;
    logic [5:0]  pd_new;
    logic [5:0]  pd_old;
    logic [31:0] imm;
    logic [4:0]  rob_tag;
  } rename_data;

  localparam logic [1:0] FU_ALU = 2'd0;
  localparam logic [1:0] FU_BR  = 2'd1;
  localparam logic [1:0] FU_LSU = 2'd2;
endpackage

module dispatch
  import dispatch_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       valid_in,
  input  rename_data r_data,
  input  logic [6:0] Opcode,
  output logic       ready_out,
  input  logic       rob_full,
  input  logic [4:0] rob_index,
  output logic       rob_alloc,
  input  logic       alu_full,
  input  logic       br_full,
  input  logic       lsu_full,
  output logic       di_en_alu,
  output logic       di_en_br,
  output logic       di_en_lsu,
  output rename_data data_out,
  output logic [6:0] opcode_out,
  output logic [1:0] fu_out,
  output logic [4:0] rob_index_out,
  input  logic       mispredict
);

  logic [1:0] count_q, count_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic       wr_ptr_q, wr_ptr_d;
  rename_data data_q [2];
  rename_data data_d [2];
  logic [6:0] op_q   [2];
  logic [6:0] op_d   [2];
  logic [1:0] fu_q   [2];
  logic [1:0] fu_d   [2];

  logic       head_valid;
  logic [1:0] head_fu;
  logic       head_st_full;
  logic       dispatch_go;
  logic       enq;
  logic [1:0] in_fu;

  // Opcode class; anything not a branch or memory op goes to the ALU.
  always_comb begin
    in_fu = FU_ALU;
    case (Opcode)
      7'b1100011, 7'b1101111, 7'b1100111: in_fu = FU_BR;
      7'b0000011, 7'b0100011:             in_fu = FU_LSU;
      default:                            in_fu = FU_ALU;
    endcase
  end

  assign ready_out = (count_q < 2'd2) && !mispredict;
  assign enq       = valid_in && ready_out;

  always_comb begin
    head_valid = (count_q != 2'd0);
    head_fu    = fu_q[rd_ptr_q];
    case (head_fu)
      FU_ALU:  head_st_full = alu_full;
      FU_BR:   head_st_full = br_full;
      FU_LSU:  head_st_full = lsu_full;
      default: head_st_full = 1'b1;
    endcase
    dispatch_go = head_valid && !rob_full && !head_st_full && !mispredict;
  end

  always_comb begin
    di_en_alu     = dispatch_go && (head_fu == FU_ALU);
    di_en_br      = dispatch_go && (head_fu == FU_BR);
    di_en_lsu     = dispatch_go && (head_fu == FU_LSU);
    rob_alloc     = dispatch_go;
    rob_index_out = rob_index;
    data_out      = '0;
    opcode_out    = '0;
    fu_out        = '0;
    if (head_valid) begin
      data_out   = data_q[rd_ptr_q];
      opcode_out = op_q[rd_ptr_q];
      fu_out     = head_fu;
    end
  end

  always_comb begin
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    data_d   = data_q;
    op_d     = op_q;
    fu_d     = fu_q;
    if (mispredict) begin
      // Flush drops everything in flight, including any instruction
      // offered this cycle (ready_out is already low).
      count_d  = 2'd0;
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
    end else begin
      if (enq) begin
        data_d[wr_ptr_q] = r_data;
        op_d[wr_ptr_q]   = Opcode;
        fu_d[wr_ptr_q]   = in_fu;
        wr_ptr_d         = ~wr_ptr_q;
      end
      if (dispatch_go) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      case ({enq, dispatch_go})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q  <= 2'd0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      data_q   <= '{default: '0};
      op_q     <= '{default: '0};
      fu_q     <= '{default: '0};
    end else begin
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      data_q   <= data_d;
      op_q     <= op_d;
      fu_q     <= fu_d;
    end
  end

endmodule

// File: tb/tb_dispatch.sv
// tb/tb_dispatch.sv - self-checking bench for dispatch: directed scenarios plus randomized model comparison
module tb_dispatch;
  import dispatch_pkg::*;

  logic       clk;
  logic       reset;
  logic       valid_in;
  rename_data r_data;
  logic [6:0] Opcode;
  logic       ready_out;
  logic       rob_full;
  logic [4:0] rob_index;
  logic       rob_alloc;
  logic       alu_full, br_full, lsu_full;
  logic       di_en_alu, di_en_br, di_en_lsu;
  rename_data data_out;
  logic [6:0] opcode_out;
  logic [1:0] fu_out;
  logic [4:0] rob_index_out;
  logic       mispredict;

  int checks;
  int failures;

  typedef struct {
    rename_data d;
    logic [6:0] op;
    logic [1:0] fu;
  } ent_t;

  ent_t mq[$];

  dispatch dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .r_data(r_data), .Opcode(Opcode),
    .ready_out(ready_out), .rob_full(rob_full), .rob_index(rob_index), .rob_alloc(rob_alloc),
    .alu_full(alu_full), .br_full(br_full), .lsu_full(lsu_full),
    .di_en_alu(di_en_alu), .di_en_br(di_en_br), .di_en_lsu(di_en_lsu),
    .data_out(data_out), .opcode_out(opcode_out), .fu_out(fu_out),
    .rob_index_out(rob_index_out), .mispredict(mispredict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [1:0] cls(input logic [6:0] op);
    if (op inside {7'b1100011, 7'b1101111, 7'b1100111}) return 2'd1;
    if (op inside {7'b0000011, 7'b0100011}) return 2'd2;
    return 2'd0;
  endfunction

  function automatic logic station_full(input logic [1:0] fu);
    if (fu == 2'd1) return br_full;
    if (fu == 2'd2) return lsu_full;
    return alu_full;
  endfunction

  // Advance the reference queue with the inputs currently applied, then clock.
  task automatic tick();
    ent_t e;
    logic disp, rdy;
    if (reset || mispredict) begin
      mq.delete();
    end else begin
      disp = (mq.size() > 0) && !rob_full && !station_full(mq[0].fu);
      rdy  = (mq.size() < 2);
      if (disp) void'(mq.pop_front());
      if (valid_in && rdy) begin
        e.d = r_data; e.op = Opcode; e.fu = cls(Opcode);
        mq.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    valid_in = 0; r_data = '0; Opcode = '0; rob_full = 0; rob_index = '0;
    alu_full = 0; br_full = 0; lsu_full = 0; mispredict = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1; valid_in = 1; Opcode = 7'b0110011; r_data.pd_new = 6'd9;
    tick(); tick();
    checks++;
    if ({di_en_alu, di_en_br, di_en_lsu, rob_alloc} !== 4'b0000) begin
      failures++; $display("FAIL reset_strobes got=%b exp=0000", {di_en_alu, di_en_br, di_en_lsu, rob_alloc});
    end
    reset = 0; valid_in = 0;
    #1;
    checks++;
    if (ready_out !== 1'b1 || fu_out !== 2'd0 || opcode_out !== 7'd0 || data_out !== '0) begin
      failures++; $display("FAIL reset_outputs got ready=%b fu=%0d op=%0h data=%0h exp ready=1 rest=0",
                           ready_out, fu_out, opcode_out, data_out);
    end
  endtask

  task automatic test_basic();
    idle_inputs();
    valid_in = 1; Opcode = 7'b0110011; r_data.pd_new = 6'd20; rob_index = 5'd3;
    tick();
    valid_in = 0;
    #1;
    checks++;
    if ({di_en_alu, di_en_br, di_en_lsu, rob_alloc} !== 4'b1001 || fu_out !== 2'd0 ||
        rob_index_out !== 5'd3 || data_out.pd_new !== 6'd20) begin
      failures++; $display("FAIL basic_dispatch got strb=%b fu=%0d robi=%0d pd=%0d exp strb=1001 fu=0 robi=3 pd=20",
                           {di_en_alu, di_en_br, di_en_lsu, rob_alloc}, fu_out, rob_index_out, data_out.pd_new);
    end
    tick();
    checks++;
    if (ready_out !== 1'b1 || rob_alloc !== 1'b0 || data_out !== '0) begin
      failures++; $display("FAIL basic_empty got ready=%b alloc=%b data=%0h exp ready=1 alloc=0 data=0",
                           ready_out, rob_alloc, data_out);
    end
  endtask

  task automatic test_routing();
    idle_inputs();
    valid_in = 1; Opcode = 7'b1100011; r_data.pd_new = 6'd1;
    tick();
    Opcode = 7'b0000011; r_data.pd_new = 6'd2;
    #1;
    checks++;
    if ({di_en_alu, di_en_br, di_en_lsu} !== 3'b010 || fu_out !== 2'd1) begin
      failures++; $display("FAIL route_br got en=%b fu=%0d exp en=010 fu=1", {di_en_alu, di_en_br, di_en_lsu}, fu_out);
    end
    tick();
    valid_in = 0;
    #1;
    checks++;
    if ({di_en_alu, di_en_br, di_en_lsu} !== 3'b001 || fu_out !== 2'd2 || data_out.pd_new !== 6'd2) begin
      failures++; $display("FAIL route_lsu got en=%b fu=%0d pd=%0d exp en=001 fu=2 pd=2",
                           {di_en_alu, di_en_br, di_en_lsu}, fu_out, data_out.pd_new);
    end
    tick();
    checks++;
    if ({di_en_alu, di_en_br, di_en_lsu} !== 3'b000) begin
      failures++; $display("FAIL route_after got en=%b exp en=000", {di_en_alu, di_en_br, di_en_lsu});
    end
  endtask

  task automatic test_backpressure();
    idle_inputs();
    br_full = 1;
    valid_in = 1; Opcode = 7'b1100111; r_data.pd_new = 6'd11;
    tick();
    Opcode = 7'b0010011; r_data.pd_new = 6'd12;
    tick();
    Opcode = 7'b0110011; r_data.pd_new = 6'd13;
    #1;
    checks++;
    if (ready_out !== 1'b0 || {di_en_alu, di_en_br, di_en_lsu, rob_alloc} !== 4'b0000 || fu_out !== 2'd1) begin
      failures++; $display("FAIL bp_blocked got ready=%b strb=%b fu=%0d exp ready=0 strb=0000 fu=1",
                           ready_out, {di_en_alu, di_en_br, di_en_lsu, rob_alloc}, fu_out);
    end
    tick();
    valid_in = 0;
    br_full = 0;
    #1;
    checks++;
    if ({di_en_alu, di_en_br, di_en_lsu} !== 3'b010 || data_out.pd_new !== 6'd11) begin
      failures++; $display("FAIL bp_branch_first got en=%b pd=%0d exp en=010 pd=11",
                           {di_en_alu, di_en_br, di_en_lsu}, data_out.pd_new);
    end
    tick();
    checks++;
    if ({di_en_alu, di_en_br, di_en_lsu} !== 3'b100 || data_out.pd_new !== 6'd12) begin
      failures++; $display("FAIL bp_alu_second got en=%b pd=%0d exp en=100 pd=12",
                           {di_en_alu, di_en_br, di_en_lsu}, data_out.pd_new);
    end
    tick();
    checks++;
    if (rob_alloc !== 1'b0 || data_out !== '0) begin
      failures++; $display("FAIL bp_third_dropped got alloc=%b data=%0h exp alloc=0 data=0", rob_alloc, data_out);
    end
  endtask

  task automatic test_rob_full();
    idle_inputs();
    rob_full = 1;
    valid_in = 1; Opcode = 7'b0110111; r_data.pd_new = 6'd30;
    tick();
    valid_in = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (rob_alloc !== 1'b0 || di_en_alu !== 1'b0) begin
        failures++; $display("FAIL robfull_hold cyc=%0d got alloc=%b alu=%b exp 0 0", i, rob_alloc, di_en_alu);
      end
      tick();
    end
    rob_full = 0;
    #1;
    checks++;
    if (rob_alloc !== 1'b1 || di_en_alu !== 1'b1 || data_out.pd_new !== 6'd30) begin
      failures++; $display("FAIL robfull_release got alloc=%b alu=%b pd=%0d exp 1 1 30", rob_alloc, di_en_alu, data_out.pd_new);
    end
    tick();
  endtask

  task automatic test_flush();
    idle_inputs();
    alu_full = 1;
    valid_in = 1; Opcode = 7'b0110011; r_data.pd_new = 6'd40;
    tick();
    r_data.pd_new = 6'd41;
    tick();
    alu_full = 0; mispredict = 1; r_data.pd_new = 6'd42;
    #1;
    checks++;
    if ({di_en_alu, di_en_br, di_en_lsu, rob_alloc} !== 4'b0000 || ready_out !== 1'b0) begin
      failures++; $display("FAIL flush_suppress got strb=%b ready=%b exp strb=0000 ready=0",
                           {di_en_alu, di_en_br, di_en_lsu, rob_alloc}, ready_out);
    end
    tick();
    mispredict = 0; valid_in = 0;
    #1;
    checks++;
    if (ready_out !== 1'b1 || rob_alloc !== 1'b0 || data_out !== '0) begin
      failures++; $display("FAIL flush_empty got ready=%b alloc=%b data=%0h exp ready=1 alloc=0 data=0",
                           ready_out, rob_alloc, data_out);
    end
  endtask

  task automatic test_reset_mid();
    idle_inputs();
    alu_full = 1;
    valid_in = 1; Opcode = 7'b0010111; r_data.pd_new = 6'd50;
    tick();
    r_data.pd_new = 6'd51;
    tick();
    valid_in = 0; reset = 1;
    tick();
    reset = 0; alu_full = 0;
    #1;
    checks++;
    if ({di_en_alu, di_en_br, di_en_lsu, rob_alloc} !== 4'b0000 || ready_out !== 1'b1 || data_out !== '0 ||
        opcode_out !== 7'd0 || fu_out !== 2'd0) begin
      failures++; $display("FAIL rstmid_clear got strb=%b ready=%b data=%0h op=%0h fu=%0d exp strb=0000 ready=1 zeros",
                           {di_en_alu, di_en_br, di_en_lsu, rob_alloc}, ready_out, data_out, opcode_out, fu_out);
    end
    valid_in = 1; Opcode = 7'b0100011; r_data.pd_new = 6'd52;
    tick();
    valid_in = 0;
    #1;
    checks++;
    if ({di_en_alu, di_en_br, di_en_lsu, rob_alloc} !== 4'b0011 || data_out.pd_new !== 6'd52) begin
      failures++; $display("FAIL rstmid_after got strb=%b pd=%0d exp strb=0011 pd=52",
                           {di_en_alu, di_en_br, di_en_lsu, rob_alloc}, data_out.pd_new);
    end
    tick();
  endtask

  task automatic test_random();
    logic [6:0] ops [10];
    logic [63:0] rr;
    logic exp_rdy, exp_disp;
    logic [1:0] hfu;
    ops = '{7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111, 7'b1100011,
            7'b1101111, 7'b1100111, 7'b0000011, 7'b0100011, 7'b0000000};
    idle_inputs();
    for (int c = 0; c < 600; c++) begin
      reset      = ($urandom_range(63) == 0);
      mispredict = ($urandom_range(15) == 0);
      valid_in   = ($urandom_range(3) != 0);
      rob_full   = ($urandom_range(4) == 0);
      alu_full   = ($urandom_range(3) == 0);
      br_full    = ($urandom_range(3) == 0);
      lsu_full   = ($urandom_range(3) == 0);
      rob_index  = 5'($urandom);
      Opcode     = ($urandom_range(4) == 0) ? 7'($urandom) : ops[$urandom_range(9)];
      rr         = {$urandom(), $urandom()};
      r_data     = rr[$bits(rename_data)-1:0];
      #1;
      if (!reset) begin
        hfu      = (mq.size() > 0) ? mq[0].fu : 2'd0;
        exp_rdy  = (mq.size() < 2) && !mispredict;
        exp_disp = (mq.size() > 0) && !rob_full && !mispredict && !station_full(hfu);
        checks++;
        if (ready_out !== exp_rdy) begin
          failures++; $display("FAIL rand_ready cyc=%0d got=%b exp=%b", c, ready_out, exp_rdy);
        end
        checks++;
        if ({di_en_alu, di_en_br, di_en_lsu, rob_alloc} !==
            (exp_disp ? {hfu == 2'd0, hfu == 2'd1, hfu == 2'd2, 1'b1} : 4'b0000)) begin
          failures++; $display("FAIL rand_strobes cyc=%0d got=%b exp_disp=%b fu=%0d", c,
                               {di_en_alu, di_en_br, di_en_lsu, rob_alloc}, exp_disp, hfu);
        end
        checks++;
        if (mq.size() > 0) begin
          if (data_out !== mq[0].d || opcode_out !== mq[0].op || fu_out !== mq[0].fu) begin
            failures++; $display("FAIL rand_head cyc=%0d got data=%0h op=%0h fu=%0d exp data=%0h op=%0h fu=%0d", c,
                                 data_out, opcode_out, fu_out, mq[0].d, mq[0].op, mq[0].fu);
          end
        end else if (data_out !== '0 || opcode_out !== 7'd0 || fu_out !== 2'd0) begin
          failures++; $display("FAIL rand_empty cyc=%0d got data=%0h op=%0h fu=%0d exp zeros", c,
                               data_out, opcode_out, fu_out);
        end
        checks++;
        if (rob_index_out !== rob_index) begin
          failures++; $display("FAIL rand_robidx cyc=%0d got=%0d exp=%0d", c, rob_index_out, rob_index);
        end
      end
      tick();
    end
    reset = 0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1;
    idle_inputs();
    test_reset();
    test_basic();
    test_routing();
    test_backpressure();
    test_rob_full();
    test_flush();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
